// File: rtl/uart_rx_framed.sv
// UART receiver: start-edge detection, mid-bit sampling, optional parity, 1-2 stop bits,
// and a valid/ack holding register with parity, framing and overrun flags.
`timescale 1ns/1ps
module uart_rx_framed #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 100,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1,
  parameter int LSB_FIRST    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 bsIn,
  input  logic                 dataAck,
  output logic [DATA_BITS-1:0] data,
  output logic                 dataValid,
  output logic                 parityErr,
  output logic                 frameErr,
  output logic                 overrun,
  output logic                 busy
);
  localparam int H  = CLKS_PER_BIT / 2;
  localparam int P  = (PARITY_EN != 0) ? 1 : 0;
  localparam int N  = DATA_BITS + P + STOP_BITS;
  localparam int BW = $clog2(N + 1);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_HALF  = CW'(H - 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(N - 1);
  localparam logic          PAR_REF   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAITHI} state_t;

  state_t               state_reg;
  logic                 sync1_reg;
  logic                 rxs_reg;
  logic [CW-1:0]        cyc_cnt_reg;
  logic [BW-1:0]        bit_cnt_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 par_reg;
  logic                 ferr_reg;
  logic                 mid_bit;
  logic                 complete;
  logic                 frame_bad;

  // cyc_cnt_reg holds (cycles since last sample point) - 1
  assign mid_bit   = (cyc_cnt_reg == CNT_FULL);
  assign complete  = (state_reg == STOP) && mid_bit && (bit_cnt_reg == LAST_BIT);
  assign frame_bad = ferr_reg | ~rxs_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_reg <= 1'b1;
      rxs_reg   <= 1'b1;
    end else begin
      sync1_reg <= bsIn;
      rxs_reg   <= sync1_reg;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      busy        <= 1'b0;
      cyc_cnt_reg <= '0;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      par_reg     <= 1'b0;
      ferr_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          cyc_cnt_reg <= '0;
          bit_cnt_reg <= '0;
          par_reg     <= 1'b0;
          ferr_reg    <= 1'b0;
          if (!rxs_reg) begin
            state_reg <= START;
            busy      <= 1'b1;
          end
        end
        START: begin
          if (cyc_cnt_reg == CNT_HALF) begin
            cyc_cnt_reg <= '0;
            if (rxs_reg) begin
              state_reg <= IDLE;
              busy      <= 1'b0;
            end else begin
              state_reg <= DATA;
            end
          end else begin
            cyc_cnt_reg <= cyc_cnt_reg + 1'b1;
          end
        end
        DATA: begin
          if (mid_bit) begin
            cyc_cnt_reg <= '0;
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
            par_reg     <= par_reg ^ rxs_reg;
            if (LSB_FIRST != 0) shift_reg <= {rxs_reg, shift_reg[DATA_BITS-1:1]};
            else                shift_reg <= {shift_reg[DATA_BITS-2:0], rxs_reg};
            if (bit_cnt_reg == LAST_DATA) state_reg <= (P != 0) ? PARITY : STOP;
          end else begin
            cyc_cnt_reg <= cyc_cnt_reg + 1'b1;
          end
        end
        PARITY: begin
          if (mid_bit) begin
            cyc_cnt_reg <= '0;
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
            par_reg     <= par_reg ^ rxs_reg;
            state_reg   <= STOP;
          end else begin
            cyc_cnt_reg <= cyc_cnt_reg + 1'b1;
          end
        end
        STOP: begin
          if (mid_bit) begin
            cyc_cnt_reg <= '0;
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
            ferr_reg    <= frame_bad;
            // A bad stop bit means a break or line fault: wait for idle before rearming
            if (bit_cnt_reg == LAST_BIT) begin
              state_reg <= frame_bad ? WAITHI : IDLE;
              busy      <= frame_bad;
            end
          end else begin
            cyc_cnt_reg <= cyc_cnt_reg + 1'b1;
          end
        end
        WAITHI: begin
          if (rxs_reg) begin
            state_reg <= IDLE;
            busy      <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data      <= '0;
      dataValid <= 1'b0;
      parityErr <= 1'b0;
      frameErr  <= 1'b0;
      overrun   <= 1'b0;
    end else if (complete) begin
      data      <= shift_reg;
      dataValid <= 1'b1;
      parityErr <= (P != 0) && (par_reg != PAR_REF);
      frameErr  <= frame_bad;
      if (dataValid && !dataAck) overrun <= 1'b1;
    end else if (dataAck && dataValid) begin
      dataValid <= 1'b0;
      parityErr <= 1'b0;
      frameErr  <= 1'b0;
      overrun   <= 1'b0;
    end
  end
endmodule

// File: tb/tb_uart_rx_framed.sv
// Directed bench for uart_rx_framed: 8N1, 8E1 and 5-bit MSB-first two-stop-bit instances
// sharing one clock and reset, each fed from a selectable serial line.
`timescale 1ns/1ps
module tb_uart_rx_framed;
  logic       clk;
  logic       rst;
  logic       line;
  logic [1:0] sel;
  logic [2:0] ack;
  logic       bs_a, bs_b, bs_c;
  int         tests, fails, cyc, t_start, rise_a, rises_a, rises_ref;
  logic       dv_a_q;

  logic [7:0] data_a, data_b;
  logic [4:0] data_c;
  logic       dv_a, pe_a, fe_a, ov_a, busy_a;
  logic       dv_b, pe_b, fe_b, ov_b, busy_b;
  logic       dv_c, pe_c, fe_c, ov_c, busy_c;
  logic [19:0] f;

  assign bs_a = (sel == 2'd0) ? line : 1'b1;
  assign bs_b = (sel == 2'd1) ? line : 1'b1;
  assign bs_c = (sel == 2'd2) ? line : 1'b1;

  uart_rx_framed #(.DATA_BITS(8), .CLKS_PER_BIT(16)) u_a (
    .clk(clk), .reset(rst), .bsIn(bs_a), .dataAck(ack[0]), .data(data_a), .dataValid(dv_a),
    .parityErr(pe_a), .frameErr(fe_a), .overrun(ov_a), .busy(busy_a));

  uart_rx_framed #(.DATA_BITS(8), .CLKS_PER_BIT(16), .PARITY_EN(1), .PARITY_ODD(0)) u_b (
    .clk(clk), .reset(rst), .bsIn(bs_b), .dataAck(ack[1]), .data(data_b), .dataValid(dv_b),
    .parityErr(pe_b), .frameErr(fe_b), .overrun(ov_b), .busy(busy_b));

  uart_rx_framed #(.DATA_BITS(5), .CLKS_PER_BIT(16), .STOP_BITS(2), .LSB_FIRST(0)) u_c (
    .clk(clk), .reset(rst), .bsIn(bs_c), .dataAck(ack[2]), .data(data_c), .dataValid(dv_c),
    .parityErr(pe_c), .frameErr(fe_c), .overrun(ov_c), .busy(busy_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    dv_a_q  = 1'b0;
    rises_a = 0;
    rise_a  = 0;
  end
  always @(negedge clk) begin
    if (dv_a && !dv_a_q) begin
      rise_a  = cyc;
      rises_a = rises_a + 1;
    end
    dv_a_q = dv_a;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // bits[0] goes on the line first; each bit is held for 16 clocks
  task automatic send(input logic [19:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      line = bits[i];
      if (i == 0) t_start = cyc;
      repeat (15) @(posedge clk);
    end
    #1;
  endtask

  task automatic pulse_ack(input int which);
    @(posedge clk); #1;
    ack[which] = 1'b1;
    @(posedge clk); #1;
    ack[which] = 1'b0;
  endtask

  initial begin
    tests = 0; fails = 0;
    rst = 1'b0; line = 1'b1; sel = 2'd0; ack = 3'b000;
    #2 rst = 1'b1;
    #1;
    chk("reset_dv_a",   dv_a, 0);
    chk("reset_data_a", data_a, 0);
    chk("reset_busy_a", busy_a, 0);
    chk("reset_ov_a",   ov_a, 0);
    chk("reset_pe_b",   pe_b, 0);
    chk("reset_fe_c",   fe_c, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (4) @(posedge clk);

    // 8N1 0x55 with exact completion latency (2 sync + H + 9 bits + 1)
    f = {10'b0, 1'b1, 8'h55, 1'b0};
    send(f, 10);
    chk("t1_latency", rise_a - t_start, 155);
    chk("t1_data",    data_a, 8'h55);
    chk("t1_pe",      pe_a, 0);
    chk("t1_fe",      fe_a, 0);
    chk("t1_busy",    busy_a, 0);
    repeat (3) @(posedge clk); #1;
    chk("t1_hold_dv", dv_a, 1);
    pulse_ack(0);
    chk("t1_ack_dv",  dv_a, 0);

    // even parity, 0xA3 has four ones
    sel = 2'd1;
    f = {9'b0, 1'b1, 1'b1, 8'hA3, 1'b0};
    send(f, 11);
    chk("t2_dv",      dv_b, 1);
    chk("t2_data",    data_b, 8'hA3);
    chk("t2_pe_bad",  pe_b, 1);
    chk("t2_fe",      fe_b, 0);
    pulse_ack(1);
    chk("t2_ack_pe",  pe_b, 0);
    f = {9'b0, 1'b1, 1'b0, 8'hA3, 1'b0};
    send(f, 11);
    chk("t2_dv2",     dv_b, 1);
    chk("t2_pe_good", pe_b, 0);
    pulse_ack(1);

    // stop bit low on 0x7E, line then held low for 40 bit-times
    sel = 2'd0;
    f = {10'b0, 1'b0, 8'h7E, 1'b0};
    send(f, 10);
    chk("t3_data",    data_a, 8'h7E);
    chk("t3_fe",      fe_a, 1);
    chk("t3_waithi",  busy_a, 1);
    rises_ref = rises_a;
    pulse_ack(0);
    repeat (640) @(posedge clk); #1;
    chk("t3_no_frame", rises_a, rises_ref);
    chk("t3_dv",      dv_a, 0);
    chk("t3_busy_lo", busy_a, 1);
    line = 1'b1;
    repeat (4) @(posedge clk); #1;
    chk("t3_busy_rel", busy_a, 0);

    // 3-cycle low glitch: START aborts when its half-bit sample sees high
    @(posedge clk); #1;
    line = 1'b0;
    repeat (3) @(posedge clk); #1;
    line = 1'b1;
    repeat (7) @(posedge clk); #1;
    chk("t4_busy_start", busy_a, 1);
    @(posedge clk); #1;
    chk("t4_busy_abort", busy_a, 0);
    chk("t4_dv",         dv_a, 0);

    // back-to-back frames without ack
    f = {10'b0, 1'b1, 8'h11, 1'b0};
    send(f, 10);
    chk("t5_data1",   data_a, 8'h11);
    chk("t5_ov1",     ov_a, 0);
    f = {10'b0, 1'b1, 8'h22, 1'b0};
    send(f, 10);
    chk("t5_data2",   data_a, 8'h22);
    chk("t5_dv2",     dv_a, 1);
    chk("t5_ov2",     ov_a, 1);
    pulse_ack(0);
    chk("t5_ack_dv",  dv_a, 0);
    chk("t5_ack_ov",  ov_a, 0);
    chk("t5_ack_fe",  fe_a, 0);
    chk("t5_ack_pe",  pe_a, 0);

    // 5 data bits MSB first, 0b10110, second stop bit low
    sel = 2'd2;
    f = 20'b0101_1010;
    send(f, 8);
    chk("t6_data",    data_c, 5'b10110);
    chk("t6_fe",      fe_c, 1);
    chk("t6_dv",      dv_c, 1);
    chk("t6_waithi",  busy_c, 1);
    line = 1'b1;
    repeat (4) @(posedge clk); #1;
    chk("t6_idle",    busy_c, 0);
    @(posedge clk); #1;
    line = 1'b0;
    repeat (40) @(posedge clk); #1;
    chk("t6_mid_busy", busy_c, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t6_rst_dv",   dv_c, 0);
    chk("t6_rst_data", data_c, 0);
    chk("t6_rst_fe",   fe_c, 0);
    chk("t6_rst_busy", busy_c, 0);
    line = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
